// File: rtl/prom_loader.sv
// prom_loader: receives a PROM image over a UART 8N1 link and writes it into a
// 32-bit wide PROM, one word per four received bytes (little-endian packing).
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit period (4..65535)
//   ADDR_W        PROM address width, depth 2**ADDR_W words
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   rx         UART serial input, idle high, asynchronous to clk
//   start      one-cycle pulse that begins or restarts a load
//   we         PROM write enable, one cycle per word
//   addr       PROM write address
//   din        PROM write data
//   busy       load in progress
//   done       last word written, held until the next start
//   frame_err  sticky: a byte with a low stop bit was seen
//   cksum_err  sticky: a word failed its checksum (0 when compiled out)
//
// Build option:
//   PROM_LOADER_CKSUM_EN  each word carries a fifth byte, the XOR of the four
//                         data bytes; mismatching words are not written.

module prom_loader #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned ADDR_W       = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    input  logic              start,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       din,
    output logic              busy,
    output logic              done,
    output logic              frame_err,
    output logic              cksum_err
);

    localparam logic [15:0]       BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0]       HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
`ifdef PROM_LOADER_CKSUM_EN
    localparam logic [2:0]        IDX_LAST  = 3'd4;
`else
    localparam logic [2:0]        IDX_LAST  = 3'd3;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    rx_state_t         r_state;
    logic              r_rx_s1;
    logic              r_rx_s2;
    logic              r_rx_prev;
    logic [15:0]       r_cnt;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              r_byte_vld;
    logic              r_frame_bad;

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_din;
    logic              r_busy;
    logic              r_done;
    logic              r_frame_err;
    logic [2:0]        r_idx;
`ifdef PROM_LOADER_CKSUM_EN
    logic [7:0]        r_xor;
    logic              r_cksum_err;
`endif

    // Receiver: synchronizer, edge detect and bit-timing FSM. Runs regardless
    // of start so a byte in flight is never cut short by a restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1     <= 1'b1;
            r_rx_s2     <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_byte_vld  <= 1'b0;
            r_frame_bad <= 1'b0;
        end else begin
            r_rx_s1     <= rx;
            r_rx_s2     <= r_rx_s1;
            r_rx_prev   <= r_rx_s2;
            r_byte_vld  <= 1'b0;
            r_frame_bad <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt     <= '0;
                    r_bit_cnt <= '0;
                    if (r_rx_prev && !r_rx_s2)
                        r_state <= START;
                end
                START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt   <= '0;
                        // rx back high at mid start bit: treat as a glitch
                        r_state <= r_rx_s2 ? IDLE : DATA;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rx_s2, r_shift[7:1]};
                        if (r_bit_cnt == 3'd7) begin
                            r_bit_cnt <= '0;
                            r_state   <= STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        if (r_rx_s2)
                            r_byte_vld  <= 1'b1;
                        else
                            r_frame_bad <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Loader: packs accepted bytes into words and sequences PROM writes.
    // start takes priority over any byte delivered in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_din       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
            r_idx       <= '0;
`ifdef PROM_LOADER_CKSUM_EN
            r_xor       <= '0;
            r_cksum_err <= 1'b0;
`endif
        end else begin
            r_we <= 1'b0;
            if (start) begin
                r_busy      <= 1'b1;
                r_done      <= 1'b0;
                r_addr      <= '0;
                r_idx       <= '0;
                r_frame_err <= 1'b0;
`ifdef PROM_LOADER_CKSUM_EN
                r_cksum_err <= 1'b0;
`endif
            end else begin
                if (r_frame_bad)
                    r_frame_err <= 1'b1;
                // address advances the cycle after a write; last write ends the load
                if (r_we) begin
                    if (r_addr == ADDR_LAST) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                if (r_byte_vld && r_busy) begin
                    if (r_idx == IDX_LAST) begin
                        r_idx <= '0;
`ifdef PROM_LOADER_CKSUM_EN
                        if (r_shift == r_xor)
                            r_we <= 1'b1;
                        else
                            r_cksum_err <= 1'b1;
`else
                        r_din[31:24] <= r_shift;
                        r_we         <= 1'b1;
`endif
                    end else begin
                        r_din[{r_idx[1:0], 3'b000} +: 8] <= r_shift;
                        r_idx <= r_idx + 3'd1;
`ifdef PROM_LOADER_CKSUM_EN
                        r_xor <= (r_idx == 3'd0) ? r_shift : (r_xor ^ r_shift);
`endif
                    end
                end
            end
        end
    end

    assign we        = r_we;
    assign addr      = r_addr;
    assign din       = r_din;
    assign busy      = r_busy;
    assign done      = r_done;
    assign frame_err = r_frame_err;
`ifdef PROM_LOADER_CKSUM_EN
    assign cksum_err = r_cksum_err;
`else
    assign cksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_prom_loader.sv
// tb_prom_loader: directed, table-driven bench for prom_loader with
// CLKS_PER_BIT=4 and ADDR_W=2 (four-word PROM).
module tb_prom_loader;

    localparam int unsigned CPB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic        start;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] din;
    logic        busy;
    logic        done;
    logic        frame_err;
    logic        cksum_err;

    int          tests = 0;
    int          fails = 0;
    int          wcount = 0;
    logic [1:0]  last_addr;
    logic [31:0] last_din;

    prom_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .start(start),
        .we(we), .addr(addr), .din(din), .busy(busy), .done(done),
        .frame_err(frame_err), .cksum_err(cksum_err)
    );

    always #5 clk = ~clk;

    // Capture every write away from the active edge.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            wcount    <= wcount + 1;
            last_addr <= addr;
            last_din  <= din;
        end
    end

    typedef struct packed {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
        logic [1:0]  exp_addr;
        logic [31:0] exp_din;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_ok);
        hold(1'b0);
        for (int i = 0; i < 8; i++) hold(d[i]);
        hold(stop_ok);
        rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Sends a word in the framing the current build expects.
    task automatic send_word(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
        send_byte(b2, 1'b1);
        send_byte(b3, 1'b1);
`ifdef PROM_LOADER_CKSUM_EN
        send_byte(b0 ^ b1 ^ b2 ^ b3, 1'b1);
`endif
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        int prev;
        vecs[0] = '{b0: 8'h78, b1: 8'h56, b2: 8'h34, b3: 8'h12, exp_addr: 2'd0, exp_din: 32'h12345678};
        vecs[1] = '{b0: 8'hEF, b1: 8'hBE, b2: 8'hAD, b3: 8'hDE, exp_addr: 2'd1, exp_din: 32'hDEADBEEF};
        vecs[2] = '{b0: 8'h00, b1: 8'hFF, b2: 8'h00, b3: 8'hFF, exp_addr: 2'd2, exp_din: 32'hFF00FF00};
        vecs[3] = '{b0: 8'h01, b1: 8'h80, b2: 8'h7E, b3: 8'hC3, exp_addr: 2'd3, exp_din: 32'hC37E8001};

        rst_n = 1'b0; rx = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_addr", {30'd0, addr}, 32'd0);
        check("reset_din",  din, 32'd0);

        // Byte arriving while idle must be ignored.
        send_byte(8'h33, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("idle_byte_no_we", wcount, 0);

        // Full load, word by word from the table.
        pulse_start();
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            prev = wcount;
            send_word(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3);
            check($sformatf("word%0d_we_count", i), wcount, prev + 1);
            check($sformatf("word%0d_addr", i), {30'd0, last_addr}, {30'd0, vecs[i].exp_addr});
            check($sformatf("word%0d_din", i), last_din, vecs[i].exp_din);
            if (i == 0) check("addr_after_first", {30'd0, addr}, 32'd1);
        end
        check("full_busy", {31'd0, busy}, 32'd0);
        check("full_done", {31'd0, done}, 32'd1);
        check("full_addr_hold", {30'd0, addr}, 32'd3);
        prev = wcount;
        send_word(8'h11, 8'h22, 8'h33, 8'h44);
        check("extra_byte_no_we", wcount, prev);
        check("extra_done", {31'd0, done}, 32'd1);

        // Framing error, then a clean word.
        pulse_start();
        check("restart_addr", {30'd0, addr}, 32'd0);
        prev = wcount;
        send_byte(8'hA5, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("frame_err_set", {31'd0, frame_err}, 32'd1);
        check("frame_no_we", wcount, prev);
        send_word(8'h0D, 8'hF0, 8'hAD, 8'h0B);
        check("frame_next_we", wcount, prev + 1);
        check("frame_next_addr", {30'd0, last_addr}, 32'd0);
        check("frame_next_din", last_din, 32'h0BADF00D);
        pulse_start();
        check("frame_err_cleared", {31'd0, frame_err}, 32'd0);

        // Single-cycle glitch on rx must not start a byte.
        prev = wcount;
        @(posedge clk); #1;
        rx = 1'b0;
        @(posedge clk); #1;
        rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        send_word(8'h44, 8'h33, 8'h22, 8'h11);
        check("glitch_we", wcount, prev + 1);
        check("glitch_din", last_din, 32'h11223344);
        check("glitch_frame", {31'd0, frame_err}, 32'd0);

        // Restart after a partial word discards it.
        pulse_start();
        prev = wcount;
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        pulse_start();
        send_word(8'h01, 8'h23, 8'h45, 8'h67);
        check("restart_we", wcount, prev + 1);
        check("restart_addr_w", {30'd0, last_addr}, 32'd0);
        check("restart_din", last_din, 32'h67452301);

`ifdef PROM_LOADER_CKSUM_EN
        pulse_start();
        prev = wcount;
        send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
        send_byte(8'h04, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        check("cksum_ok_we", wcount, prev + 1);
        check("cksum_ok_din", last_din, 32'h04030201);
        send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        check("cksum_bad_err", {31'd0, cksum_err}, 32'd1);
        check("cksum_bad_no_we", wcount, prev + 1);
        check("cksum_bad_addr", {30'd0, addr}, 32'd1);
`else
        check("cksum_err_tied", {31'd0, cksum_err}, 32'd0);
`endif

        // Reset during the third bit of byte 2.
        pulse_start();
        send_byte(8'hC3, 1'b1);
        send_byte(8'h3C, 1'b1);
        hold(1'b0);
        hold(1'b1);
        hold(1'b0);
        rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_we",   {31'd0, we}, 32'd0);
        check("rst_addr", {30'd0, addr}, 32'd0);
        check("rst_din",  din, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_cerr", {31'd0, cksum_err}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("post_rst_idle", {31'd0, busy}, 32'd0);
        pulse_start();
        prev = wcount;
        send_word(8'h9A, 8'hBC, 8'hDE, 8'hF0);
        check("post_rst_we", wcount, prev + 1);
        check("post_rst_addr", {30'd0, last_addr}, 32'd0);
        check("post_rst_din", last_din, 32'hF0DEBC9A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prom_loader.md
PROM_LOADER -- requirements
Module: prom_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104: clk cycles per UART bit period; legal range 4..65535.
REQ-002 Parameter ADDR_W, default 11: PROM address width; depth is 2**ADDR_W words.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port rx  input  1  UART 8N1 serial data, idle high, asynchronous to clk.
REQ-006 Port start  input  1  single-cycle pulse that begins or restarts a load.
REQ-007 Port we  output  1  PROM write enable, asserted for one cycle per word.
REQ-008 Port addr  output  ADDR_W  PROM write address.
REQ-009 Port din  output  32  PROM write data.
REQ-010 Port busy  output  1  high while a load is in progress.
REQ-011 Port done  output  1  high after the last PROM word is written, until the next start.
REQ-012 Port frame_err  output  1  sticky flag: a byte with a bad stop bit was received.
REQ-013 Port cksum_err  output  1  sticky flag: a word failed checksum; tied 0 when checksum is compiled out.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-015 Receiver FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-016 IDLE->START SHALL occur on a synchronized falling edge of rx.
REQ-017 In START, rx SHALL be sampled at CLKS_PER_BIT/2: low goes to DATA, high returns to IDLE (glitch reject).
REQ-018 DATA SHALL sample 8 bits, LSB first, each a full CLKS_PER_BIT after the previous sample.
REQ-019 STOP SHALL sample rx one bit period later: high delivers the byte; low sets frame_err, discards the byte and returns to IDLE.
REQ-020 Bytes SHALL be accepted only while busy=1; bytes arriving while busy=0 are received and discarded.
REQ-021 Accepted bytes SHALL be packed little-endian: byte 0 -> din[7:0], byte 3 -> din[31:24].
REQ-022 On the 4th byte of a word, we SHALL pulse for exactly one cycle with din and addr stable in that cycle.
REQ-023 addr SHALL increment by 1 in the cycle after each write.
REQ-024 The write at addr = 2**ADDR_W-1 SHALL be the last: the next cycle sets busy=0 and done=1, with addr holding its value (no wrap).
REQ-025 start SHALL set busy=1 and done=0, clear addr, the byte index and both error flags, and discard any partial word.
REQ-026 start while busy SHALL restart the load identically.
REQ-027 If start and byte delivery occur in the same cycle, start SHALL win and the byte SHALL be discarded.
REQ-028 A receiver byte in progress SHALL NOT be aborted by start.

Reset
REQ-029 rst_n low SHALL immediately force: we=0, addr=0, din=0, busy=0, done=0, frame_err=0, cksum_err=0, FSM=IDLE, byte index=0, bit counter=0, synchronizer flops=1.
REQ-030 Reset asserted mid-byte or mid-word SHALL discard all partial data; after release the block idles until start.

Configuration
REQ-031 Macro PROM_LOADER_CKSUM_EN SHALL gate checksum checking.
REQ-032 With PROM_LOADER_CKSUM_EN defined, each word is 5 bytes: 4 data bytes, then the XOR of those 4 bytes.
REQ-033 With PROM_LOADER_CKSUM_EN defined, a matching checksum SHALL write the word per REQ-022..024.
REQ-034 With PROM_LOADER_CKSUM_EN defined, a mismatch SHALL set cksum_err, suppress we, hold addr and reset the byte index.
REQ-035 Without PROM_LOADER_CKSUM_EN, words SHALL be 4 bytes and cksum_err SHALL be constant 0.

Verification (bench: CLKS_PER_BIT=4, ADDR_W=2 unless noted)
REQ-036 Single word: start, then bytes 0x78 0x56 0x34 0x12 -> one we pulse, din=0x12345678, addr=0; addr=1 next cycle.
REQ-037 Full load: start, then 16 bytes -> 4 we pulses at addr 0..3; afterwards busy=0, done=1, addr=3; a 17th byte produces no we.
REQ-038 Framing: byte 0xA5 sent with stop bit low -> frame_err=1, no byte counted; the next 4 valid bytes form word 0.
REQ-039 Glitch and restart: a 1-cycle low pulse on rx -> no byte received; start after 2 bytes, then 4 bytes -> write at addr=0 using only the last 4 bytes.
REQ-040 With PROM_LOADER_CKSUM_EN defined: bytes 01 02 03 04 04 -> write 0x04030201; bytes 01 02 03 04 00 -> cksum_err=1, no we, addr unchanged.
REQ-041 Reset: assert rst_n low during the 3rd bit of byte 2 -> all outputs 0 immediately; after release, start plus 4 bytes -> write at addr=0.
